// File: rtl/intr_seq.sv
`default_nettype none
// ============================================================================
// Module   : intr_seq
// Purpose  : mc6502 RES/NMI/IRQ/BRK entry sequencer; owns datapath controls
//            while BUSY=1 to push PCH/PCL/P, fetch the vector and set I.
// Revision : 1.0 - initial release
// ============================================================================
module intr_seq #(
    parameter logic [3:0] P_ALU_DEC = 4'hd,
    parameter int         P_I_BIT   = 2
) (
    input  logic       CLK,
    input  logic       RES_N,
    input  logic       NMI_N,
    input  logic       IRQ_N,
    input  logic       BRK_REQ,
    input  logic       INSTR_END,
    input  logic [8:0] FLAG,
    output logic       BUSY,
    output logic       MEM_WE,
    output logic       PUSH_B,
    output logic [2:0] DB_OUT_SRC,
    output logic [1:0] PCL_SRC,
    output logic       PCH_SRC,
    output logic       PCL_WE,
    output logic       PCH_WE,
    output logic       S_WE,
    output logic       ABL_WE,
    output logic       ABH_WE,
    output logic [2:0] REG_SRC,
    output logic [3:0] ALU_CTRL,
    output logic [2:0] ALU_SRC_A,
    output logic       ALU_SRC_B,
    output logic [2:0] P_SRC,
    output logic [7:0] P_MASK,
    output logic [2:0] ABL_SRC,
    output logic [2:0] ABH_SRC,
    output logic       VEC_OVR,
    output logic [7:0] VEC_LO
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_reset = 3'd1;
    localparam logic [2:0] c_st_a0    = 3'd2;
    localparam logic [2:0] c_st_w_pch = 3'd3;
    localparam logic [2:0] c_st_w_pcl = 3'd4;
    localparam logic [2:0] c_st_w_p   = 3'd5;
    localparam logic [2:0] c_st_r_vl  = 3'd6;
    localparam logic [2:0] c_st_r_vh  = 3'd7;

    localparam logic [1:0] c_kind_res = 2'd0;
    localparam logic [1:0] c_kind_nmi = 2'd1;
    localparam logic [1:0] c_kind_irq = 2'd2;
    localparam logic [1:0] c_kind_brk = 2'd3;

    localparam logic [1:0] c_vec_norm = 2'd0;
    localparam logic [1:0] c_vec_nmi  = 2'd1;
    localparam logic [1:0] c_vec_res  = 2'd2;

    localparam logic [7:0] c_i_mask = 8'(1 << P_I_BIT);

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [1:0] r_kind;
    logic [1:0] w_kind_nxt;
    logic [1:0] r_vec;
    logic [1:0] w_vec_sel;
    logic       r_nmi_s1;
    logic       r_nmi_s2;
    logic       r_nmi_latch;
    logic       w_nmi_fall;
    logic       w_nmi_pend;
    logic       w_nmi_commit;
    logic       w_i_flag;
    logic       w_flag_unused;

    assign w_i_flag      = FLAG[P_I_BIT];
    assign w_flag_unused = ^FLAG;

    // A fall still in the synchronizer counts as pending, so an NMI arriving
    // late in a BRK/IRQ entry can still take over the vector at W_P.
    assign w_nmi_fall   = r_nmi_s2 & ~r_nmi_s1;
    assign w_nmi_pend   = r_nmi_latch | w_nmi_fall;
    assign w_nmi_commit = (r_state == c_st_w_p) && (r_kind != c_kind_res) && w_nmi_pend;

    always_comb begin
        if (r_kind == c_kind_res) begin
            w_vec_sel = c_vec_res;
        end else if (w_nmi_pend) begin
            w_vec_sel = c_vec_nmi;
        end else begin
            w_vec_sel = c_vec_norm;
        end
    end

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            r_state <= c_st_reset;
            r_kind  <= c_kind_res;
        end else begin
            r_state <= w_state_nxt;
            r_kind  <= w_kind_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            r_nmi_s1    <= 1'b1;
            r_nmi_s2    <= 1'b1;
            r_nmi_latch <= 1'b0;
            r_vec       <= c_vec_norm;
        end else begin
            r_nmi_s1 <= NMI_N;
            r_nmi_s2 <= r_nmi_s1;
            if (w_nmi_commit) begin
                r_nmi_latch <= 1'b0;
            end else if (w_nmi_fall) begin
                r_nmi_latch <= 1'b1;
            end
            if (r_state == c_st_w_p) begin
                r_vec <= w_vec_sel;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_kind_nxt  = r_kind;
        case (r_state)
            c_st_idle: begin
                if (INSTR_END) begin
                    if (r_nmi_latch) begin
                        w_state_nxt = c_st_a0;
                        w_kind_nxt  = c_kind_nmi;
                    end else if (!IRQ_N && !w_i_flag) begin
                        w_state_nxt = c_st_a0;
                        w_kind_nxt  = c_kind_irq;
                    end else if (BRK_REQ) begin
                        w_state_nxt = c_st_a0;
                        w_kind_nxt  = c_kind_brk;
                    end
                end
            end
            c_st_reset: w_state_nxt = c_st_a0;
            c_st_a0:    w_state_nxt = c_st_w_pch;
            c_st_w_pch: w_state_nxt = c_st_w_pcl;
            c_st_w_pcl: w_state_nxt = c_st_w_p;
            c_st_w_p:   w_state_nxt = c_st_r_vl;
            c_st_r_vl:  w_state_nxt = c_st_r_vh;
            c_st_r_vh:  w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        BUSY       = 1'b0;
        MEM_WE     = 1'b0;
        PUSH_B     = 1'b0;
        DB_OUT_SRC = 3'd0;
        PCL_SRC    = 2'd0;
        PCH_SRC    = 1'b0;
        PCL_WE     = 1'b0;
        PCH_WE     = 1'b0;
        S_WE       = 1'b0;
        ABL_WE     = 1'b0;
        ABH_WE     = 1'b0;
        REG_SRC    = 3'd0;
        ALU_CTRL   = 4'd0;
        ALU_SRC_A  = 3'd0;
        ALU_SRC_B  = 1'b0;
        P_SRC      = 3'd5;
        P_MASK     = 8'd0;
        ABL_SRC    = 3'd0;
        ABH_SRC    = 3'd0;
        VEC_OVR    = 1'b0;
        VEC_LO     = 8'd0;

        BUSY = (r_state != c_st_idle) && (r_state != c_st_reset);

        // Push cycles: write the stack slot addressed last cycle, S <- S-1.
        if ((r_state == c_st_w_pch) || (r_state == c_st_w_pcl) || (r_state == c_st_w_p)) begin
            MEM_WE    = (r_kind != c_kind_res);
            REG_SRC   = 3'd7;
            ALU_SRC_A = 3'd3;
            ALU_SRC_B = 1'b1;
            ALU_CTRL  = P_ALU_DEC;
            S_WE      = 1'b1;
        end

        case (r_state)
            c_st_a0: begin
                ABL_SRC = 3'd4;
                ABH_SRC = 3'd5;
                ABL_WE  = 1'b1;
                ABH_WE  = 1'b1;
            end
            c_st_w_pch: begin
                DB_OUT_SRC = 3'd6;
                ABL_SRC    = 3'd3;
                ABL_WE     = 1'b1;
            end
            c_st_w_pcl: begin
                DB_OUT_SRC = 3'd5;
                ABL_SRC    = 3'd3;
                ABL_WE     = 1'b1;
            end
            c_st_w_p: begin
                DB_OUT_SRC = 3'd4;
                PUSH_B     = (r_kind == c_kind_brk);
                ABH_SRC    = 3'd6;
                ABL_WE     = 1'b1;
                ABH_WE     = 1'b1;
                case (w_vec_sel)
                    c_vec_res: begin
                        VEC_OVR = 1'b1;
                        VEC_LO  = 8'hfc;
                    end
                    c_vec_nmi: begin
                        VEC_OVR = 1'b1;
                        VEC_LO  = 8'hfa;
                    end
                    default:   ABL_SRC = 3'd6;
                endcase
            end
            c_st_r_vl: begin
                PCL_SRC = 2'd1;
                PCL_WE  = 1'b1;
                ABL_WE  = 1'b1;
                case (r_vec)
                    c_vec_res: begin
                        VEC_OVR = 1'b1;
                        VEC_LO  = 8'hfd;
                    end
                    c_vec_nmi: begin
                        VEC_OVR = 1'b1;
                        VEC_LO  = 8'hfb;
                    end
                    default:   ABL_SRC = 3'd7;
                endcase
            end
            c_st_r_vh: begin
                PCH_SRC = 1'b1;
                PCH_WE  = 1'b1;
                P_SRC   = 3'd3;
                P_MASK  = c_i_mask;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_intr_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_intr_seq
// Purpose  : directed bench for intr_seq around a small 6502 datapath model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intr_seq;

    logic       CLK = 1'b0;
    logic       RES_N = 1'b0;
    logic       NMI_N = 1'b1;
    logic       IRQ_N = 1'b1;
    logic       BRK_REQ = 1'b0;
    logic       INSTR_END = 1'b0;
    logic [8:0] FLAG;
    logic       BUSY, MEM_WE, PUSH_B, PCH_SRC, PCL_WE, PCH_WE, S_WE, ABL_WE, ABH_WE;
    logic       ALU_SRC_B, VEC_OVR;
    logic [2:0] DB_OUT_SRC, REG_SRC, ALU_SRC_A, P_SRC, ABL_SRC, ABH_SRC;
    logic [1:0] PCL_SRC;
    logic [3:0] ALU_CTRL;
    logic [7:0] P_MASK, VEC_LO;

    intr_seq #(.P_ALU_DEC(4'hd), .P_I_BIT(2)) u_dut (
        .CLK(CLK), .RES_N(RES_N), .NMI_N(NMI_N), .IRQ_N(IRQ_N), .BRK_REQ(BRK_REQ),
        .INSTR_END(INSTR_END), .FLAG(FLAG), .BUSY(BUSY), .MEM_WE(MEM_WE),
        .PUSH_B(PUSH_B), .DB_OUT_SRC(DB_OUT_SRC), .PCL_SRC(PCL_SRC), .PCH_SRC(PCH_SRC),
        .PCL_WE(PCL_WE), .PCH_WE(PCH_WE), .S_WE(S_WE), .ABL_WE(ABL_WE), .ABH_WE(ABH_WE),
        .REG_SRC(REG_SRC), .ALU_CTRL(ALU_CTRL), .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B),
        .P_SRC(P_SRC), .P_MASK(P_MASK), .ABL_SRC(ABL_SRC), .ABH_SRC(ABH_SRC),
        .VEC_OVR(VEC_OVR), .VEC_LO(VEC_LO)
    );

    always #5 CLK = ~CLK;

    // Datapath model: registers, bus log and vector ROM.
    logic        ld = 1'b0;
    logic [7:0]  ld_s = 8'h00, ld_pch = 8'h00, ld_pcl = 8'h00, ld_p = 8'h00;
    logic [7:0]  m_s = 8'h00, m_pch = 8'h00, m_pcl = 8'h00, m_p = 8'h00;
    logic [7:0]  m_abl = 8'h00, m_abh = 8'h00;
    logic [15:0] wr_a [0:7];
    logic [7:0]  wr_d [0:7];
    int          wr_cnt = 0;
    int          busy_cnt = 0;
    logic [15:0] rd_lo = 16'h0, rd_hi = 16'h0;
    logic [15:0] w_ab;
    logic [7:0]  w_alu, w_dbo, w_dbi, w_abl_nxt, w_abh_nxt;

    assign FLAG = {1'b0, m_p};
    assign w_ab = {m_abh, m_abl};

    always_comb begin
        w_alu = (ALU_CTRL == 4'hd && ALU_SRC_A == 3'd3 && ALU_SRC_B) ? m_s - 8'd1 : 8'h00;
        case (DB_OUT_SRC)
            3'd4:    w_dbo = m_p | {3'b000, PUSH_B, 4'b0000};
            3'd5:    w_dbo = m_pcl;
            3'd6:    w_dbo = m_pch;
            default: w_dbo = 8'h00;
        endcase
        case (w_ab)
            16'hfffa: w_dbi = 8'h11;
            16'hfffb: w_dbi = 8'h22;
            16'hfffc: w_dbi = 8'h33;
            16'hfffd: w_dbi = 8'h44;
            16'hfffe: w_dbi = 8'h55;
            16'hffff: w_dbi = 8'h66;
            default:  w_dbi = 8'h00;
        endcase
        if (VEC_OVR) begin
            w_abl_nxt = VEC_LO;
        end else begin
            case (ABL_SRC)
                3'd3:    w_abl_nxt = w_alu;
                3'd4:    w_abl_nxt = m_s;
                3'd6:    w_abl_nxt = 8'hfe;
                3'd7:    w_abl_nxt = 8'hff;
                default: w_abl_nxt = 8'h00;
            endcase
        end
        case (ABH_SRC)
            3'd5:    w_abh_nxt = 8'h01;
            3'd6:    w_abh_nxt = 8'hff;
            default: w_abh_nxt = 8'h00;
        endcase
    end

    always @(posedge CLK) begin
        if (ld) begin
            m_s <= ld_s; m_pch <= ld_pch; m_pcl <= ld_pcl; m_p <= ld_p;
            wr_cnt <= 0; busy_cnt <= 0; rd_lo <= 16'h0; rd_hi <= 16'h0;
        end else begin
            if (S_WE && REG_SRC == 3'd7) m_s <= w_alu;
            if (ABL_WE) m_abl <= w_abl_nxt;
            if (ABH_WE) m_abh <= w_abh_nxt;
            if (PCL_WE && PCL_SRC == 2'd1) m_pcl <= w_dbi;
            if (PCH_WE && PCH_SRC) m_pch <= w_dbi;
            if (PCL_WE) rd_lo <= w_ab;
            if (PCH_WE) rd_hi <= w_ab;
            if (P_SRC == 3'd3) m_p <= m_p | P_MASK;
            else if (P_SRC != 3'd5) m_p <= 8'h00;
            if (MEM_WE) begin
                if (wr_cnt < 8) begin
                    wr_a[wr_cnt[2:0]] <= w_ab;
                    wr_d[wr_cnt[2:0]] <= w_dbo;
                end
                wr_cnt <= wr_cnt + 1;
            end
            if (BUSY) busy_cnt <= busy_cnt + 1;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic load(input logic [7:0] s, input logic [15:0] pc, input logic [7:0] p);
        @(negedge CLK);
        ld = 1'b1; ld_s = s; ld_pch = pc[15:8]; ld_pcl = pc[7:0]; ld_p = p;
        @(negedge CLK);
        ld = 1'b0;
    endtask

    task automatic wait_done(output bit done);
        bit seen = 1'b0;
        int n = 0;
        while (n < 30 && !(seen && !BUSY)) begin
            seen = seen | BUSY;
            @(negedge CLK);
            n++;
        end
        done = seen && !BUSY;
    endtask

    // Start a sequence at the next boundary; optionally drop NMI_N in W_PCL.
    task automatic seq(input bit brk, input bit nmi_mid, output bit done);
        BRK_REQ = brk;
        INSTR_END = 1'b1;
        @(posedge CLK); #1;
        INSTR_END = 1'b0;
        BRK_REQ = 1'b0;
        if (nmi_mid) begin
            @(posedge CLK);
            @(posedge CLK); #1;
            NMI_N = 1'b0;
        end
        wait_done(done);
    endtask

    task automatic chk_push3(input string tag, input logic [15:0] a0, input logic [7:0] d0,
                             input logic [15:0] a1, input logic [7:0] d1,
                             input logic [15:0] a2, input logic [7:0] d2);
        chk({tag, " nwr"}, 64'(wr_cnt), 64'd3);
        chk({tag, " wr0"}, {40'd0, wr_a[0], wr_d[0]}, {40'd0, a0, d0});
        chk({tag, " wr1"}, {40'd0, wr_a[1], wr_d[1]}, {40'd0, a1, d1});
        chk({tag, " wr2"}, {40'd0, wr_a[2], wr_d[2]}, {40'd0, a2, d2});
    endtask

    initial begin
        bit done;

        // Reset: idle defaults on every output, then the RES sequence.
        load(8'hfe, 16'h0000, 8'h00);
        @(negedge CLK);
        chk("reset outputs",
            {BUSY, MEM_WE, PUSH_B, DB_OUT_SRC, PCL_SRC, PCH_SRC, PCL_WE, PCH_WE, S_WE,
             ABL_WE, ABH_WE, REG_SRC, ALU_CTRL, ALU_SRC_A, ALU_SRC_B, P_SRC, P_MASK,
             ABL_SRC, ABH_SRC, VEC_OVR, VEC_LO},
            {1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0,
             3'd0, 1'b0, 3'd5, 8'd0, 3'd0, 3'd0, 1'b0, 8'd0});
        RES_N = 1'b1;
        wait_done(done);
        chk("res done", 64'(done), 64'd1);
        chk("res cycles", 64'(busy_cnt), 64'd6);
        chk("res no writes", 64'(wr_cnt), 64'd0);
        chk("res vec reads", {32'd0, rd_lo, rd_hi}, {32'd0, 16'hfffc, 16'hfffd});
        chk("res pc", {48'd0, m_pch, m_pcl}, 64'h4433);
        chk("res s", 64'(m_s), 64'hfb);
        chk("res i", 64'(m_p[2]), 64'd1);

        // IRQ from PC=1234, S=FF, I=0.
        load(8'hff, 16'h1234, 8'hc1);
        IRQ_N = 1'b0;
        seq(1'b0, 1'b0, done);
        chk("irq done", 64'(done), 64'd1);
        chk_push3("irq", 16'h01ff, 8'h12, 16'h01fe, 8'h34, 16'h01fd, 8'hc1);
        chk("irq vec reads", {32'd0, rd_lo, rd_hi}, {32'd0, 16'hfffe, 16'hffff});
        chk("irq pc", {48'd0, m_pch, m_pcl}, 64'h6655);
        chk("irq s", 64'(m_s), 64'hfc);
        chk("irq i", 64'(m_p[2]), 64'd1);

        // Masked IRQ: I=1 now, repeated boundaries do nothing.
        load(8'hfc, 16'h6655, 8'hc5);
        INSTR_END = 1'b1;
        repeat (5) @(negedge CLK);
        INSTR_END = 1'b0;
        @(negedge CLK);
        chk("masked busy", 64'(busy_cnt), 64'd0);
        chk("masked writes", 64'(wr_cnt), 64'd0);
        IRQ_N = 1'b1;

        // BRK from PC=2002.
        load(8'hff, 16'h2002, 8'h00);
        seq(1'b1, 1'b0, done);
        chk("brk done", 64'(done), 64'd1);
        chk_push3("brk", 16'h01ff, 8'h20, 16'h01fe, 8'h02, 16'h01fd, 8'h10);
        chk("brk vec lo", 64'(rd_lo), 64'hfffe);
        chk("brk pc", {48'd0, m_pch, m_pcl}, 64'h6655);

        // BRK hijacked by an NMI falling during W_PCL.
        load(8'hff, 16'h3004, 8'h00);
        seq(1'b1, 1'b1, done);
        chk("hijack done", 64'(done), 64'd1);
        chk_push3("hijack", 16'h01ff, 8'h30, 16'h01fe, 8'h04, 16'h01fd, 8'h10);
        chk("hijack vec reads", {32'd0, rd_lo, rd_hi}, {32'd0, 16'hfffa, 16'hfffb});
        chk("hijack pc", {48'd0, m_pch, m_pcl}, 64'h2211);
        load(8'hfc, 16'h2211, 8'h00);
        INSTR_END = 1'b1;
        repeat (3) @(negedge CLK);
        INSTR_END = 1'b0;
        @(negedge CLK);
        chk("no second nmi", 64'(busy_cnt), 64'd0);
        NMI_N = 1'b1;
        repeat (3) @(negedge CLK);

        // Stack wrap: S=01.
        load(8'h01, 16'h5678, 8'h00);
        IRQ_N = 1'b0;
        seq(1'b0, 1'b0, done);
        IRQ_N = 1'b1;
        chk("wrap done", 64'(done), 64'd1);
        chk_push3("wrap", 16'h0101, 8'h56, 16'h0100, 8'h78, 16'h01ff, 8'h00);
        chk("wrap s", 64'(m_s), 64'hfe);

        // NMI wins over a simultaneous IRQ and BRK.
        load(8'hff, 16'habcd, 8'h00);
        NMI_N = 1'b0;
        repeat (4) @(negedge CLK);
        IRQ_N = 1'b0;
        seq(1'b1, 1'b0, done);
        IRQ_N = 1'b1;
        NMI_N = 1'b1;
        chk("nmi done", 64'(done), 64'd1);
        chk_push3("nmi", 16'h01ff, 8'hab, 16'h01fe, 8'hcd, 16'h01fd, 8'h00);
        chk("nmi vec reads", {32'd0, rd_lo, rd_hi}, {32'd0, 16'hfffa, 16'hfffb});
        chk("nmi pc", {48'd0, m_pch, m_pcl}, 64'h2211);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
